// File: rtl/gray_n.sv
// gray_n: free-running N-bit Gray counter with a cycle-aligned binary value, a one-hot change mask and a wrap pulse.
// Optional: define GRAY_N_CHECK_EN to build a sticky single-bit-change checker that drives err.
module gray_n #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  output logic [N-1:0] gray_code,
  output logic [N-1:0] bin_code,
  output logic [N-1:0] chg_onehot,
  output logic         wrap,
  output logic         err
);

  logic [N-1:0] bin_q;
  logic [N-1:0] gray_q;
  logic [N-1:0] chg_q;
  logic         wrap_q;

  logic [N-1:0] bin_next;
  logic [N-1:0] gray_next;

  // The Gray value is computed from the next binary value and registered on
  // the same edge, so gray_code comes straight from a flop with no added latency.
  assign bin_next  = bin_q + N'(1);
  assign gray_next = bin_next ^ (bin_next >> 1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bin_q  <= '0;
      gray_q <= '0;
      chg_q  <= '0;
      wrap_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments mean gray_q on the right-hand side is
      // still the previous value, which is exactly what the change mask needs.
      bin_q  <= bin_next;
      gray_q <= gray_next;
      chg_q  <= gray_next ^ gray_q;
      wrap_q <= (bin_next == '0);
    end
  end

  assign gray_code  = gray_q;
  assign bin_code   = bin_q;
  assign chg_onehot = chg_q;
  assign wrap       = wrap_q;

`ifdef GRAY_N_CHECK_EN
  logic [N-1:0] prev_gray_q;
  logic [N-1:0] gray_diff;
  logic         chk_valid_q;
  logic         err_q;
  logic         one_bit_diff;

  // A single set bit is non-zero and clears when ANDed with itself minus one.
  assign gray_diff    = gray_q ^ prev_gray_q;
  assign one_bit_diff = (gray_diff != '0) && ((gray_diff & (gray_diff - N'(1))) == '0);

  // chk_valid_q skips the first comparison after reset, whose "previous"
  // value is the reset state rather than a counted value.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prev_gray_q <= '0;
      chk_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      prev_gray_q <= gray_q;
      chk_valid_q <= 1'b1;
      if (chk_valid_q && !one_bit_diff) begin
        err_q <= 1'b1;
      end
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_gray_n.sv
// Self-checking bench for gray_n: an N=8 instance for sequence, wrap and reset cases,
// and an N=4 instance for the exhaustive one-bit-change property.
module tb_gray_n;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst8_n;
  logic       rst4_n;
  logic [7:0] g8, b8, c8;
  logic       w8, e8;
  logic [3:0] g4, b4, c4;
  logic       w4, e4;

  gray_n #(.N(8)) dut8 (
    .clk       (clk),
    .rst_n     (rst8_n),
    .gray_code (g8),
    .bin_code  (b8),
    .chg_onehot(c8),
    .wrap      (w8),
    .err       (e8)
  );

  gray_n #(.N(4)) dut4 (
    .clk       (clk),
    .rst_n     (rst4_n),
    .gray_code (g4),
    .bin_code  (b4),
    .chg_onehot(c4),
    .wrap      (w4),
    .err       (e4)
  );

  typedef struct {
    logic [31:0] gray;
    logic [31:0] bin;
    logic [31:0] chg;
    logic        wrap;
  } exp_t;

  exp_t q8[$];
  exp_t q4[$];

  int n_pass  = 0;
  int n_total = 0;

  logic [7:0] m8_bin, m8_gray;
  logic [3:0] m4_bin, m4_gray;
  logic [3:0] prev4;
  bit         prev4_valid = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic pop_check(input string tag, ref exp_t q[$], input logic [31:0] g,
                           input logic [31:0] b, input logic [31:0] c, input logic w);
    exp_t e;
    if (q.size() == 0) begin
      check({tag, "_queue_empty"}, 32'd0, 32'd1);
    end else begin
      e = q.pop_front();
      check({tag, "_gray"}, g, e.gray);
      check({tag, "_bin"},  b, e.bin);
      check({tag, "_chg"},  c, e.chg);
      check({tag, "_wrap"}, {31'd0, w}, {31'd0, e.wrap});
    end
  endtask

  // Drive one edge on both instances: push model expectations, clock, then compare.
  task automatic tick(input logic r8, input logic r4);
    exp_t       e;
    logic [7:0] nb8, ng8;
    logic [3:0] nb4, ng4;
    rst8_n = r8;
    rst4_n = r4;

    if (!r8) begin
      m8_bin = '0; m8_gray = '0;
      e = '{32'd0, 32'd0, 32'd0, 1'b0};
    end else begin
      nb8 = m8_bin + 8'd1;
      ng8 = nb8 ^ (nb8 >> 1);
      e.gray = {24'd0, ng8};
      e.bin  = {24'd0, nb8};
      e.chg  = {24'd0, ng8 ^ m8_gray};
      e.wrap = (nb8 == 8'd0);
      m8_bin = nb8; m8_gray = ng8;
    end
    q8.push_back(e);

    if (!r4) begin
      m4_bin = '0; m4_gray = '0;
      e = '{32'd0, 32'd0, 32'd0, 1'b0};
    end else begin
      nb4 = m4_bin + 4'd1;
      ng4 = nb4 ^ (nb4 >> 1);
      e.gray = {28'd0, ng4};
      e.bin  = {28'd0, nb4};
      e.chg  = {28'd0, ng4 ^ m4_gray};
      e.wrap = (nb4 == 4'd0);
      m4_bin = nb4; m4_gray = ng4;
    end
    q4.push_back(e);

    @(posedge clk);
    #1;
    pop_check("n8", q8, {24'd0, g8}, {24'd0, b8}, {24'd0, c8}, w8);
    pop_check("n4", q4, {28'd0, g4}, {28'd0, b4}, {28'd0, c4}, w4);
    check("n8_err", {31'd0, e8}, 32'd0);
    check("n4_err", {31'd0, e4}, 32'd0);

    if (r4) begin
      check("n4_gray_rel", {28'd0, g4}, {28'd0, b4 ^ (b4 >> 1)});
      if (prev4_valid) check("n4_one_bit", $countones(g4 ^ prev4), 32'd1);
    end
    prev4       = g4;
    prev4_valid = 1'b1;
  endtask

  logic [7:0] seq_gray [5] = '{8'b00000001, 8'b00000011, 8'b00000010, 8'b00000110, 8'b00000111};
  logic [7:0] seq_chg  [5] = '{8'b00000001, 8'b00000010, 8'b00000001, 8'b00000100, 8'b00000001};

  initial begin
    rst8_n = 1'b0;
    rst4_n = 1'b0;

    // Reset state
    tick(1'b0, 1'b0);
    check("rst_gray", {24'd0, g8}, 32'd0);
    check("rst_bin",  {24'd0, b8}, 32'd0);
    check("rst_chg",  {24'd0, c8}, 32'd0);
    check("rst_wrap", {31'd0, w8}, 32'd0);

    // First five counts against literal values
    for (int i = 0; i < 5; i++) begin
      tick(1'b1, 1'b0);
      check("seq_gray", {24'd0, g8}, {24'd0, seq_gray[i]});
      check("seq_bin",  {24'd0, b8}, i + 1);
      check("seq_chg",  {24'd0, c8}, {24'd0, seq_chg[i]});
    end

    // Up to edge 255, then across the wrap
    for (int i = 6; i <= 255; i++) tick(1'b1, 1'b0);
    check("e255_gray", {24'd0, g8}, 32'h80);
    check("e255_wrap", {31'd0, w8}, 32'd0);
    tick(1'b1, 1'b0);
    check("e256_gray", {24'd0, g8}, 32'h00);
    check("e256_wrap", {31'd0, w8}, 32'd1);
    check("e256_chg",  {24'd0, c8}, 32'h80);
    tick(1'b1, 1'b0);
    check("e257_gray", {24'd0, g8}, 32'h01);
    check("e257_wrap", {31'd0, w8}, 32'd0);

    // Mid-run reset at count 100
    for (int i = 2; i <= 100; i++) tick(1'b1, 1'b0);
    check("c100_bin", {24'd0, b8}, 32'd100);
    tick(1'b0, 1'b0);
    check("mid_rst_gray", {24'd0, g8}, 32'd0);
    check("mid_rst_bin",  {24'd0, b8}, 32'd0);
    check("mid_rst_chg",  {24'd0, c8}, 32'd0);
    check("mid_rst_wrap", {31'd0, w8}, 32'd0);
    tick(1'b1, 1'b0);
    check("post_rst_gray", {24'd0, g8}, 32'd1);

    // N=4 exhaustive property run over 40 edges (covers two wraps)
    for (int i = 0; i < 40; i++) tick(1'b1, 1'b1);
    check("n4_e40_bin", {28'd0, b4}, 32'd8);

    // Long run: err must stay low on both instances
    for (int i = 0; i < 1000; i++) tick(1'b1, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/gray_n.md
GRAY_N -- requirements
Module: gray_n

Interface
REQ-001 SHALL have parameter N, default 8, meaning counter width in bits; legal range 2..32.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-004 SHALL have port gray_code, output, N bits: current Gray-coded count, driven directly from a register.
REQ-005 SHALL have port bin_code, output, N bits: binary equivalent of gray_code, registered and cycle-aligned with it.
REQ-006 SHALL have port chg_onehot, output, N bits: one-hot mask of the gray_code bit that changed on the last update.
REQ-007 SHALL have port wrap, output, 1 bit: one-cycle pulse marking the roll-over to zero.
REQ-008 SHALL have port err, output, 1 bit: sticky single-bit-change violation flag; present only per REQ-020.

Function
REQ-009 SHALL free-run with no enable: every rising edge with rst_n=1 advances the count by exactly one.
REQ-010 SHALL hold an internal N-bit binary counter bin; gray_code SHALL equal bin XOR (bin >> 1) at all times.
REQ-011 SHALL compute next state as bin_next = bin + 1 modulo 2^N, with gray_code_next = bin_next XOR (bin_next >> 1), both registered on the same edge.
REQ-012 SHALL make the Gray value valid in the same cycle as the binary value, with zero added latency and no combinational glitch path to gray_code.
REQ-013 SHALL make consecutive gray_code values differ in exactly one bit, including across wrap-around.
REQ-014 SHALL wrap as follows: when bin is all-ones (gray_code = 1 followed by N-1 zeros), the next edge SHALL produce bin = 0 and gray_code = 0.
REQ-015 SHALL register chg_onehot = gray_code_next XOR gray_code on each advancing edge.
REQ-016 SHALL assert wrap for exactly the one cycle in which gray_code is 0 as a result of a wrap-around, and SHALL NOT assert it when gray_code is 0 as a result of reset.

Reset
REQ-017 SHALL, on a rising edge with rst_n=0, set gray_code, bin_code, chg_onehot and wrap to 0, and clear err.
REQ-018 SHALL honour reset at any point mid-count with priority over counting; the first edge with rst_n=1 SHALL yield gray_code = 1.
REQ-019 SHALL not assume any output value before the first reset edge.

Configuration
REQ-020 SHALL use macro GRAY_N_CHECK_EN. When defined: a built-in checker compares each new gray_code against its previous value, and err is set and held until reset if the popcount of the difference is not exactly 1 (reset edges excluded). When not defined: the checker logic is absent and err is tied to 0.

Verification
REQ-021 SHALL cover the count sequence with N=8: rst_n low, then high; after 1, 2, 3, 4, 5 edges gray_code SHALL be 00000001, 00000011, 00000010, 00000110, 00000111, bin_code SHALL be 1..5, and chg_onehot SHALL be 00000001, 00000010, 00000001, 00000100, 00000001.
REQ-022 SHALL cover wrap with N=8: after 255 edges gray_code = 10000000 and wrap = 0; after 256 edges gray_code = 00000000, wrap = 1, chg_onehot = 10000000; after 257 edges gray_code = 00000001 and wrap = 0.
REQ-023 SHALL cover reset mid-run: drive rst_n low for one edge at count 100; outputs SHALL be 0 with wrap = 0; the next edge SHALL give gray_code = 00000001.
REQ-024 SHALL run an exhaustive property check with N=4 over 40 edges: every transition differs in exactly one bit, and gray_code equals bin_code XOR (bin_code >> 1) every cycle.
REQ-025 SHALL cover the macro: with GRAY_N_CHECK_EN defined over 1000 cycles err stays 0; without the macro err reads 0 constantly.
